// File: rtl/heartbeat_sequencer_if.sv
// -----------------------------------------------------------------------------
// heartbeat_sequencer_if
//
// Purpose: groups the rate-request inputs and beat outputs of
// heartbeat_sequencer into one bundle.
//
// Signals:
//   ena        run enable                       (master -> slave)
//   heartbeat  requested 2-bit rate code        (master -> slave)
//   beat       high during systole              (slave -> master)
//   beat_pulse one-clk strobe at each beat start (slave -> master)
//   rate_code  rate code currently in effect    (slave -> master)
//   beat_count beats started, or 0 when the counter is not built
//   dbg_state  current FSM state (0 IDLE, 1 SYSTOLE, 2 DIASTOLE)
//
// Handshake: there is no valid/ready pair. ena is a level: while high the
// sequencer runs; heartbeat is sampled only on beat-start edges; every
// output is a register updated on the rising clk edge.
// -----------------------------------------------------------------------------
interface heartbeat_sequencer_if;
   logic       ena;
   logic [1:0] heartbeat;
   logic       beat;
   logic       beat_pulse;
   logic [1:0] rate_code;
   logic [7:0] beat_count;
   logic [1:0] dbg_state;

   modport master (
      output ena,
      output heartbeat,
      input  beat,
      input  beat_pulse,
      input  rate_code,
      input  beat_count,
      input  dbg_state
   );

   modport slave (
      input  ena,
      input  heartbeat,
      output beat,
      output beat_pulse,
      output rate_code,
      output beat_count,
      output dbg_state
   );
endinterface

// File: rtl/heartbeat_sequencer.sv
// -----------------------------------------------------------------------------
// heartbeat_sequencer
//
// Purpose: converts a 2-bit heartbeat rate code into a timed systole/diastole
// beat waveform. A prescaler divides clk into ticks; a three-state FSM
// counts ticks per beat. The rate code is latched only at beat start, so a
// beat in progress is never truncated or stretched by a rate change.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   hb     heartbeat_sequencer_if.slave: ena, heartbeat in;
//          beat, beat_pulse, rate_code, beat_count, dbg_state out
//
// Optional feature: define HEARTBEAT_BEAT_COUNT_EN to build the 8-bit
// wrapping beat counter; without it beat_count is tied to 0.
// -----------------------------------------------------------------------------
module heartbeat_sequencer #(
   parameter int unsigned TICK_DIV      = 1000,
   parameter int unsigned PERIOD_FAST   = 4,
   parameter int unsigned PERIOD_NORMAL = 6,
   parameter int unsigned PERIOD_SLOW   = 8,
   parameter int unsigned PERIOD_SLEEP  = 12,
   parameter int unsigned SYSTOLE_TICKS = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   heartbeat_sequencer_if.slave  hb
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SYSTOLE  = 2'd1,
      S_DIASTOLE = 2'd2
   } state_e;

   // Compare against "last" values so the counters never need a wider adder.
   localparam logic [15:0] PRE_LAST    = 16'(TICK_DIV - 1);
   localparam logic [3:0]  SYS_LAST    = 4'(SYSTOLE_TICKS - 1);
   localparam logic [3:0]  FAST_LAST   = 4'(PERIOD_FAST - 1);
   localparam logic [3:0]  NORMAL_LAST = 4'(PERIOD_NORMAL - 1);
   localparam logic [3:0]  SLOW_LAST   = 4'(PERIOD_SLOW - 1);
   localparam logic [3:0]  SLEEP_LAST  = 4'(PERIOD_SLEEP - 1);

   state_e      state_q;
   logic [15:0] pre_q;
   logic [15:0] pre_d;
   logic [3:0]  phase_q;
   logic [1:0]  rate_q;
   logic        beat_q;
   logic        pulse_q;
   logic        tick;
   logic [3:0]  period_last;

   // ---------------------------------------------------------------------------
   // Prescaler: held at 0 while paused or idle so a resumed beat always gets
   // a full first tick.
   // ---------------------------------------------------------------------------
   always_comb begin
      tick = (pre_q == PRE_LAST);
   end

   always_comb begin
      pre_d = pre_q;
      if (!hb.ena || (state_q == S_IDLE)) begin
         pre_d = '0;
      end else if (tick) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + 16'd1;
      end
   end

   // Period of the beat in progress, taken from the latched code.
   always_comb begin
      period_last = FAST_LAST;
      case (rate_q)
         2'd0:    period_last = FAST_LAST;
         2'd1:    period_last = NORMAL_LAST;
         2'd2:    period_last = SLOW_LAST;
         default: period_last = SLEEP_LAST;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Beat FSM with registered outputs. beat_q tracks the next state being
   // SYSTOLE so it is high exactly while the FSM sits in SYSTOLE.
   // ---------------------------------------------------------------------------
`ifdef HEARTBEAT_BEAT_COUNT_EN
   logic [7:0] count_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         phase_q <= '0;
         rate_q  <= '0;
         beat_q  <= 1'b0;
         pulse_q <= 1'b0;
`ifdef HEARTBEAT_BEAT_COUNT_EN
         count_q <= '0;
`endif
      end else begin
         pre_q   <= pre_d;
         pulse_q <= 1'b0;
         if (!hb.ena) begin
            // Pause: rate_q and the beat counter are held on purpose.
            state_q <= S_IDLE;
            phase_q <= '0;
            beat_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_SYSTOLE;
                  phase_q <= '0;
                  rate_q  <= hb.heartbeat;
                  beat_q  <= 1'b1;
                  pulse_q <= 1'b1;
`ifdef HEARTBEAT_BEAT_COUNT_EN
                  count_q <= count_q + 8'd1;
`endif
               end
               S_SYSTOLE: begin
                  if (tick) begin
                     phase_q <= phase_q + 4'd1;
                     if (phase_q == SYS_LAST) begin
                        state_q <= S_DIASTOLE;
                        beat_q  <= 1'b0;
                     end
                  end
               end
               S_DIASTOLE: begin
                  if (tick) begin
                     if (phase_q == period_last) begin
                        // Beat boundary: the only place a new code is taken.
                        state_q <= S_SYSTOLE;
                        phase_q <= '0;
                        rate_q  <= hb.heartbeat;
                        beat_q  <= 1'b1;
                        pulse_q <= 1'b1;
`ifdef HEARTBEAT_BEAT_COUNT_EN
                        count_q <= count_q + 8'd1;
`endif
                     end else begin
                        phase_q <= phase_q + 4'd1;
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  phase_q <= '0;
                  beat_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign hb.beat       = beat_q;
   assign hb.beat_pulse = pulse_q;
   assign hb.rate_code  = rate_q;
   assign hb.dbg_state  = state_q;
`ifdef HEARTBEAT_BEAT_COUNT_EN
   assign hb.beat_count = count_q;
`else
   assign hb.beat_count = 8'd0;
`endif

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_heartbeat_sequencer
//
// Bench for heartbeat_sequencer with TICK_DIV=2 and default periods. Builds
// per-clk stimulus/expectation records from beat-level timing (period and
// systole lengths in clk), applies them, and compares the DUT outputs after
// each rising edge. Covers reset, normal rate, mid-beat rate change, the
// beat-boundary sample, pause/resume, async reset mid-systole and the
// counter wrap (expected count follows HEARTBEAT_BEAT_COUNT_EN).
// -----------------------------------------------------------------------------
module tb_heartbeat_sequencer;

   localparam int TICK_DIV  = 2;
   localparam int SYS_TICKS = 2;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   heartbeat_sequencer_if hb_if ();

   heartbeat_sequencer #(
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hb    (hb_if)
   );

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic       ena;
      logic [1:0] hb;
      logic       exp_beat;
      logic       exp_pulse;
      logic [1:0] exp_rate;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t        vec_q[$];
   logic [11:0] exp_q[$];

   int         n_cmp = 0;
   int         n_fail = 0;
   int         beats_started = 0;
   logic [1:0] cur_rate = 2'd0;

   function automatic int period_ticks(input logic [1:0] code);
      case (code)
         2'd0:    return 4;
         2'd1:    return 6;
         2'd2:    return 8;
         default: return 12;
      endcase
   endfunction

   function automatic logic [7:0] model_count();
`ifdef HEARTBEAT_BEAT_COUNT_EN
      return 8'(beats_started);
`else
      return 8'd0;
`endif
   endfunction

   function automatic logic [11:0] pack(input logic b, input logic p,
                                        input logic [1:0] r, input logic [7:0] c);
      return {b, p, r, c};
   endfunction

   // One beat starting with heartbeat=code on the start edge, then hb_rest.
   // len > 0 cuts the beat short after len clk (for pause tests).
   task automatic add_beat(input logic [1:0] code, input logic [1:0] hb_rest,
                           input int len);
      vec_t v;
      int   full;
      int   n;
      full = period_ticks(code) * TICK_DIV;
      n = (len <= 0 || len > full) ? full : len;
      beats_started++;
      cur_rate = code;
      for (int i = 0; i < n; i++) begin
         v.ena       = 1'b1;
         v.hb        = (i == 0) ? code : hb_rest;
         v.exp_beat  = (i < SYS_TICKS * TICK_DIV);
         v.exp_pulse = (i == 0);
         v.exp_rate  = code;
         v.exp_cnt   = model_count();
         vec_q.push_back(v);
      end
   endtask

   task automatic add_idle(input int n, input logic [1:0] hb_val);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.ena       = 1'b0;
         v.hb        = hb_val;
         v.exp_beat  = 1'b0;
         v.exp_pulse = 1'b0;
         v.exp_rate  = cur_rate;
         v.exp_cnt   = model_count();
         vec_q.push_back(v);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard
   task automatic check(input string name, input logic [11:0] got,
                        input logic [11:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got beat=%0b pulse=%0b rate=%0d cnt=%0d, expected beat=%0b pulse=%0b rate=%0d cnt=%0d",
                  name, got[11], got[10], got[9:8], got[7:0],
                  exp[11], exp[10], exp[9:8], exp[7:0]);
      end
   endtask

   function automatic logic [11:0] dut_outs();
      return pack(hb_if.beat, hb_if.beat_pulse, hb_if.rate_code, hb_if.beat_count);
   endfunction

   // ---------------------------------------------------------------- driver
   task automatic run_table(input string tag);
      logic [11:0] exp;
      for (int i = 0; i < vec_q.size(); i++) begin
         @(negedge clk);
         hb_if.ena       = vec_q[i].ena;
         hb_if.heartbeat = vec_q[i].hb;
         exp_q.push_back(pack(vec_q[i].exp_beat, vec_q[i].exp_pulse,
                              vec_q[i].exp_rate, vec_q[i].exp_cnt));
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         check($sformatf("%s[%0d]", tag, i), dut_outs(), exp);
      end
      vec_q.delete();
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- test
   initial begin
      rst_n           = 1'b0;
      hb_if.ena       = 1'b0;
      hb_if.heartbeat = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", dut_outs(), 12'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Normal rate, mid-beat change, boundary sample, pause/resume.
      add_idle(3, 2'd1);
      add_beat(2'd1, 2'd1, 0);   // code 1: 12 clk, 4 high
      add_beat(2'd1, 2'd1, 0);
      add_beat(2'd1, 2'd1, 0);
      add_beat(2'd0, 2'd3, 0);   // code 0 taken at start; 3 arrives in systole
      add_beat(2'd3, 2'd3, 0);   // 3 applies only now: 24 clk
      add_beat(2'd2, 2'd1, 0);   // 3->2 on the exact boundary clk
      add_beat(2'd1, 2'd1, 7);   // pause in diastole
      add_idle(3, 2'd1);
      add_beat(2'd2, 2'd2, 0);   // fresh beat, full systole
      add_beat(2'd2, 2'd2, 3);   // pause mid-systole
      add_idle(2, 2'd0);
      add_beat(2'd0, 2'd0, 0);
      add_beat(2'd1, 2'd1, 3);   // leave DUT mid-systole for the reset test
      run_table("seq");

      // Asynchronous reset mid-systole, away from any clock edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", dut_outs(), 12'd0);
      hb_if.ena = 1'b0;
      @(negedge clk);
      #1;
      check("reset_hold", dut_outs(), 12'd0);
      rst_n = 1'b1;
      beats_started = 0;
      cur_rate = 2'd0;

      // 256 beats at code 0: count wraps back to 0 (macro) or stays 0.
      add_idle(2, 2'd0);
      for (int b = 0; b < 256; b++) begin
         add_beat(2'd0, 2'd0, 0);
      end
      add_idle(2, 2'd0);
      run_table("wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
